bp_initiator: RTL and testbench
===============================

BP_INITIATOR -- requirements
Module: bp_initiator

Interface
REQ-001 Parameter TIMEOUT_W, default 16: width of the response-timeout counter; timeout is (2**TIMEOUT_W)-1 enabled cycles.
REQ-002 Parameter ADDR_W, default 7: register address width; fixed at 7 because the address byte carries the write flag in bit 7.
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_cg  input  1  clock-gate enable; state updates only when high.
REQ-006 i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake.
REQ-007 i_cmd_wr  input  1  1 = write, 0 = read.
REQ-008 i_cmd_addr  input  7  register address.
REQ-009 i_cmd_wdata  input  8  write data; ignored for reads.
REQ-010 o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake.
REQ-011 o_rsp_data  output  8  read data (read) or previous register value (write).
REQ-012 o_rsp_timeout  output  1  response was synthesised by the timeout, not received.
REQ-013 o_bp_data / o_bp_valid / i_bp_ready  out/out/in  8/1/1  byte stream towards the responder.
REQ-014 i_bp_data / i_bp_valid / o_bp_ready  in/in/out  8/1/1  byte stream from the responder.
REQ-015 o_stray  output  1  one-cycle pulse when an unsolicited byte is discarded.

Function
REQ-016 Wire protocol: the address byte is {wr, addr[6:0]}; a write sends the address byte then one data byte; a read sends the address byte only.
REQ-017 Exactly one response byte is expected per transaction.
REQ-018 All handshakes are valid/ready: a transfer occurs on a cycle where valid, ready and i_cg are all high; valid and data shall not change until the transfer.
REQ-019 State machine: IDLE, ADDR, DATA, WAIT, RSP.
REQ-020 IDLE: o_cmd_ready=1; on command transfer, latch wr/addr/wdata and go to ADDR.
REQ-021 ADDR: o_bp_valid=1, o_bp_data={wr,addr}; on transfer go to DATA if wr, else go to WAIT.
REQ-022 DATA: o_bp_valid=1, o_bp_data=wdata; on transfer go to WAIT.
REQ-023 WAIT: o_bp_ready=1; on receiving a byte, latch it, set timeout=0 and go to RSP.
REQ-024 WAIT timeout: the counter clears on entry to WAIT and increments each enabled cycle; when it reaches all-ones, set o_rsp_data=0x00, timeout=1 and go to RSP.
REQ-025 Byte arriving on the same cycle as expiry: the byte takes priority and timeout=0.
REQ-026 RSP: o_rsp_valid=1; on response transfer go to IDLE.
REQ-027 RSP same-cycle command: o_cmd_ready stays 0 in RSP, so no command is accepted on the response-transfer cycle.
REQ-028 Minimum latency, read: command accept to o_rsp_valid = 3 cycles, given an immediately ready and responding peer.
REQ-029 Minimum latency, write: command accept to o_rsp_valid = 4 cycles.
REQ-030 Stray bytes: o_bp_ready=1 in IDLE, ADDR and DATA; any received byte is discarded and o_stray pulses for one cycle.
REQ-031 Stray bytes shall never be presented as a response.
REQ-032 i_cg low: state, counters and latched data are frozen, no transfers occur and o_stray=0; outputs hold their values.
REQ-033 Back-to-back commands are serialised; at most one transaction is outstanding.

Reset
REQ-034 Reset asserted: state=IDLE, o_cmd_ready=1, o_bp_valid=0, o_bp_data=0x00, o_bp_ready=1.
REQ-035 Reset asserted: o_rsp_valid=0, o_rsp_data=0x00, o_rsp_timeout=0, o_stray=0, timeout counter=0.
REQ-036 Reset mid-transaction abandons the transaction with no response; the first post-reset response byte from the peer is treated as stray.

Structure
REQ-037 Shared package bpPkg holds the state enum, the write-flag bit index (7), and the response-byte count (1).
REQ-038 The timeout counter is a natural sub-module, bpTimeout (clear, enable, expired), reusable by other bytepipe blocks.
REQ-039 Everything else is a single always_ff FSM plus registered outputs.

Verification
REQ-040 Read addr 0x05, peer ready, returns 0xA5 after 2 cycles -> bp out 0x05; rsp 0xA5, timeout=0, 3 cycles after accept plus peer delay.
REQ-041 Write addr 0x12 data 0x3C, peer returns 0x77 -> bp out 0x92 then 0x3C; rsp 0x77, timeout=0.
REQ-042 Read with silent peer, TIMEOUT_W=4 -> rsp 0x00, timeout=1 exactly 15 cycles after WAIT entry.
REQ-043 i_bp_ready low 5 cycles during ADDR, i_rsp_ready low 3 cycles during RSP -> data held stable, no duplicate bytes, o_cmd_ready=0 throughout.
REQ-044 Stray 0xEE in IDLE; i_cg low 4 cycles mid-WAIT; i_rst_n pulse in DATA -> o_stray pulses once; counter frozen; outputs return to reset values asynchronously.

Source files
------------

// File: rtl/bp_initiator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bpPkg (package)
//  Purpose  : Shared definitions for the bytepipe initiator: FSM state
//             encoding, wire-protocol constants and the address-byte builder.
//  Revision : 1.0  initial release
// ============================================================================
package bpPkg;

    // Initiator transaction states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_WAIT = 3'd3,
        ST_RSP  = 3'd4
    } bpState_t;

    // Bit of the address byte that carries the write flag
    localparam int WR_BIT    = 7;
    // Response bytes expected per transaction
    localparam int RSP_BYTES = 1;

    // Address byte on the wire: {wr, addr[6:0]}
    function automatic logic [7:0] addrByte(input logic wr, input logic [6:0] addr);
        logic [7:0] b;
        b         = {1'b0, addr};
        b[WR_BIT] = wr;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_initiator_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : bpTimeout
//  Purpose  : Response-timeout counter for bytepipe blocks. Clears on
//             i_clr, counts on i_en. o_expired flags the enabled cycle whose
//             increment brings the count to all-ones, so the owner can act on
//             the same edge the counter reaches its limit.
//  Ports    : i_clk, i_rst_n (async, active-low), i_clr, i_en, o_expired
//  Revision : 1.0  initial release
// ============================================================================
module bpTimeout #(
    parameter int TIMEOUT_W = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] c_allOnes = '1;
    localparam logic [TIMEOUT_W-1:0] c_preLast = c_allOnes - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_allOnes)) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    assign o_expired = i_en && (r_count == c_preLast);

endmodule
`default_nettype wire

// File: rtl/bp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : bp_initiator
//  Purpose  : Bytepipe register-access initiator. Accepts one read/write
//             command, serialises it as an address byte (plus a data byte
//             for writes) towards the responder, waits for exactly one
//             response byte (or a timeout) and returns it as a response.
//  Ports    : i_clk, i_rst_n     clock, async active-low reset
//             i_cg               clock-gate enable
//             i_cmd_*/o_cmd_ready  command in   (valid/ready)
//             o_rsp_*/i_rsp_ready  response out (valid/ready)
//             o_bp_*/i_bp_ready    bytes to responder
//             i_bp_*/o_bp_ready    bytes from responder
//             o_stray            pulse when an unsolicited byte is dropped
//  Revision : 1.0  initial release
// ============================================================================
module bp_initiator
    import bpPkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int ADDR_W    = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cg,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_wr,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [7:0]        i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [7:0]        o_rsp_data,
    output logic              o_rsp_timeout,
    output logic [7:0]        o_bp_data,
    output logic              o_bp_valid,
    input  logic              i_bp_ready,
    input  logic [7:0]        i_bp_data,
    input  logic              i_bp_valid,
    output logic              o_bp_ready,
    output logic              o_stray
);

    bpState_t   r_state;
    logic       r_wr;
    logic [7:0] r_wdata;

    logic w_byteIn;
    logic w_tmoClr;
    logic w_tmoEn;
    logic w_expired;

    assign w_byteIn = i_bp_valid && o_bp_ready;
    // Counter sits at zero outside WAIT so it always starts fresh on entry
    assign w_tmoClr = i_cg && (r_state != ST_WAIT);
    assign w_tmoEn  = i_cg && (r_state == ST_WAIT);

    bpTimeout #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_tmoClr),
        .i_en      (w_tmoEn),
        .o_expired (w_expired)
    );

    // Outputs are registered and set on the transition into each state.
    // The address byte lives in o_bp_data itself, so only wr/wdata are kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_wr          <= 1'b0;
            r_wdata       <= 8'h00;
            o_cmd_ready   <= 1'b1;
            o_bp_valid    <= 1'b0;
            o_bp_data     <= 8'h00;
            o_bp_ready    <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= 8'h00;
            o_rsp_timeout <= 1'b0;
            o_stray       <= 1'b0;
        end else begin
            o_stray <= 1'b0;
            if (i_cg) begin
                // Any byte taken outside WAIT is unsolicited and dropped
                o_stray <= w_byteIn && (r_state != ST_WAIT);
                case (r_state)
                    ST_IDLE: begin
                        if (i_cmd_valid) begin
                            r_wr        <= i_cmd_wr;
                            r_wdata     <= i_cmd_wdata;
                            o_cmd_ready <= 1'b0;
                            o_bp_valid  <= 1'b1;
                            o_bp_data   <= addrByte(i_cmd_wr, i_cmd_addr);
                            r_state     <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (i_bp_ready) begin
                            if (r_wr) begin
                                o_bp_data <= r_wdata;
                                r_state   <= ST_DATA;
                            end else begin
                                o_bp_valid <= 1'b0;
                                o_bp_data  <= 8'h00;
                                r_state    <= ST_WAIT;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (i_bp_ready) begin
                            o_bp_valid <= 1'b0;
                            o_bp_data  <= 8'h00;
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // A real byte wins over a timeout in the same cycle
                        if (w_byteIn) begin
                            o_rsp_valid   <= 1'b1;
                            o_rsp_data    <= i_bp_data;
                            o_rsp_timeout <= 1'b0;
                            o_bp_ready    <= 1'b0;
                            r_state       <= ST_RSP;
                        end else if (w_expired) begin
                            o_rsp_valid   <= 1'b1;
                            o_rsp_data    <= 8'h00;
                            o_rsp_timeout <= 1'b1;
                            o_bp_ready    <= 1'b0;
                            r_state       <= ST_RSP;
                        end
                    end
                    ST_RSP: begin
                        // Command ready only returns in IDLE: no overlap
                        if (i_rsp_ready) begin
                            o_rsp_valid <= 1'b0;
                            o_cmd_ready <= 1'b1;
                            o_bp_ready  <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        o_cmd_ready <= 1'b1;
                        o_bp_valid  <= 1'b0;
                        o_bp_data   <= 8'h00;
                        o_bp_ready  <= 1'b1;
                        o_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_initiator
//  Purpose  : Directed self-checking bench for bp_initiator (TIMEOUT_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_initiator;

    logic       clk;
    logic       rst_n;
    logic       cg;
    logic       cmdValid;
    logic       cmdReady;
    logic       cmdWr;
    logic [6:0] cmdAddr;
    logic [7:0] cmdWdata;
    logic       rspValid;
    logic       rspReady;
    logic [7:0] rspData;
    logic       rspTimeout;
    logic [7:0] bpOutData;
    logic       bpOutValid;
    logic       bpOutReady;
    logic [7:0] bpInData;
    logic       bpInValid;
    logic       bpInReady;
    logic       stray;

    int nCmp   = 0;
    int nErr   = 0;
    int nBpOut = 0;

    bp_initiator #(
        .TIMEOUT_W (4),
        .ADDR_W    (7)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cg          (cg),
        .i_cmd_valid   (cmdValid),
        .o_cmd_ready   (cmdReady),
        .i_cmd_wr      (cmdWr),
        .i_cmd_addr    (cmdAddr),
        .i_cmd_wdata   (cmdWdata),
        .o_rsp_valid   (rspValid),
        .i_rsp_ready   (rspReady),
        .o_rsp_data    (rspData),
        .o_rsp_timeout (rspTimeout),
        .o_bp_data     (bpOutData),
        .o_bp_valid    (bpOutValid),
        .i_bp_ready    (bpOutReady),
        .i_bp_data     (bpInData),
        .i_bp_valid    (bpInValid),
        .o_bp_ready    (bpInReady),
        .o_stray       (stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count bytes actually transferred towards the responder
    always @(posedge clk) begin
        if (rst_n && cg && bpOutValid && bpOutReady) nBpOut <= nBpOut + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
        cmdValid = 1'b1;
        cmdWr    = wr;
        cmdAddr  = addr;
        cmdWdata = wdata;
        step();
        cmdValid = 1'b0;
    endtask

    initial begin
        int early;
        int base;
        rst_n      = 1'b0;
        cg         = 1'b1;
        cmdValid   = 1'b0;
        cmdWr      = 1'b0;
        cmdAddr    = 7'h00;
        cmdWdata   = 8'h00;
        rspReady   = 1'b1;
        bpOutReady = 1'b1;
        bpInValid  = 1'b0;
        bpInData   = 8'h00;
        step();
        step();

        // ---------------- reset state ----------------
        checkVal("rst_cmd_ready", cmdReady, 1);
        checkVal("rst_bp_valid", bpOutValid, 0);
        checkVal("rst_bp_data", bpOutData, 8'h00);
        checkVal("rst_bp_ready", bpInReady, 1);
        checkVal("rst_rsp_valid", rspValid, 0);
        checkVal("rst_rsp_data", rspData, 8'h00);
        checkVal("rst_rsp_timeout", rspTimeout, 0);
        checkVal("rst_stray", stray, 0);
        rst_n = 1'b1;
        step();

        // ---------------- read 0x05, peer answers after 2 cycles ----------------
        base = nBpOut;
        sendCmd(1'b0, 7'h05, 8'hFF);                 // cycle 1: ADDR
        checkVal("rd_addr_valid", bpOutValid, 1);
        checkVal("rd_addr_byte", bpOutData, 8'h05);
        checkVal("rd_cmd_busy", cmdReady, 0);
        step();                                      // cycle 2: WAIT
        checkVal("rd_bp_done", bpOutValid, 0);
        step();                                      // cycle 3
        checkVal("rd_rsp_early3", rspValid, 0);
        step();                                      // cycle 4
        checkVal("rd_rsp_early4", rspValid, 0);
        bpInValid = 1'b1;
        bpInData  = 8'hA5;
        step();                                      // cycle 5 = 3 + 2
        bpInValid = 1'b0;
        checkVal("rd_rsp_valid", rspValid, 1);
        checkVal("rd_rsp_data", rspData, 8'hA5);
        checkVal("rd_rsp_timeout", rspTimeout, 0);
        checkVal("rd_no_stray", stray, 0);
        checkVal("rd_bytes_out", nBpOut - base, 1);
        step();
        checkVal("rd_rsp_taken", rspValid, 0);
        checkVal("rd_cmd_ready", cmdReady, 1);

        // ---------------- write 0x12 <= 0x3C, peer answers 0x77 ----------------
        base = nBpOut;
        sendCmd(1'b1, 7'h12, 8'h3C);                 // cycle 1: ADDR
        checkVal("wr_addr_byte", bpOutData, 8'h92);
        checkVal("wr_addr_valid", bpOutValid, 1);
        step();                                      // cycle 2: DATA
        checkVal("wr_data_byte", bpOutData, 8'h3C);
        checkVal("wr_data_valid", bpOutValid, 1);
        step();                                      // cycle 3: WAIT
        checkVal("wr_bp_done", bpOutValid, 0);
        checkVal("wr_rsp_early", rspValid, 0);
        bpInValid = 1'b1;
        bpInData  = 8'h77;
        step();                                      // cycle 4
        bpInValid = 1'b0;
        checkVal("wr_rsp_valid", rspValid, 1);
        checkVal("wr_rsp_data", rspData, 8'h77);
        checkVal("wr_rsp_timeout", rspTimeout, 0);
        checkVal("wr_bytes_out", nBpOut - base, 2);
        step();

        // ---------------- read with silent peer: timeout after 15 ----------------
        sendCmd(1'b0, 7'h33, 8'h00);
        step();                                      // WAIT entry
        early = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (rspValid) early++;
        end
        checkVal("tmo_not_early", early, 0);
        step();
        checkVal("tmo_rsp_valid", rspValid, 1);
        checkVal("tmo_rsp_data", rspData, 8'h00);
        checkVal("tmo_flag", rspTimeout, 1);
        step();

        // ---------------- byte on the expiry cycle wins ----------------
        sendCmd(1'b0, 7'h34, 8'h00);
        step();
        for (int i = 0; i < 14; i++) step();
        bpInValid = 1'b1;
        bpInData  = 8'h5A;
        step();
        bpInValid = 1'b0;
        checkVal("prio_rsp_valid", rspValid, 1);
        checkVal("prio_rsp_data", rspData, 8'h5A);
        checkVal("prio_timeout", rspTimeout, 0);
        checkVal("prio_no_stray", stray, 0);
        step();

        // ---------------- backpressure in ADDR and RSP ----------------
        base       = nBpOut;
        bpOutReady = 1'b0;
        sendCmd(1'b0, 7'h41, 8'h00);
        for (int i = 0; i < 5; i++) begin
            checkVal("bpr_valid_held", bpOutValid, 1);
            checkVal("bpr_data_held", bpOutData, 8'h41);
            checkVal("bpr_cmd_busy", cmdReady, 0);
            step();
        end
        bpOutReady = 1'b1;
        step();                                      // WAIT
        checkVal("bpr_no_dup", bpOutValid, 0);
        checkVal("bpr_bytes_out", nBpOut - base, 1);
        bpInValid = 1'b1;
        bpInData  = 8'h99;
        step();                                      // RSP
        bpInValid = 1'b0;
        rspReady  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkVal("rspbp_valid_held", rspValid, 1);
            checkVal("rspbp_data_held", rspData, 8'h99);
            checkVal("rspbp_cmd_busy", cmdReady, 0);
            step();
        end
        // Command offered on the response-transfer cycle is not taken
        rspReady = 1'b1;
        cmdValid = 1'b1;
        cmdWr    = 1'b0;
        cmdAddr  = 7'h01;
        step();
        checkVal("rsp_cmd_not_taken", bpOutValid, 0);
        checkVal("rsp_back_idle", cmdReady, 1);
        checkVal("rsp_done", rspValid, 0);
        step();
        cmdValid = 1'b0;
        checkVal("next_cmd_taken", bpOutValid, 1);
        checkVal("next_cmd_byte", bpOutData, 8'h01);
        step();
        bpInValid = 1'b1;
        bpInData  = 8'h10;
        step();
        bpInValid = 1'b0;
        checkVal("next_rsp_data", rspData, 8'h10);
        step();

        // ---------------- stray byte in IDLE ----------------
        bpInValid = 1'b1;
        bpInData  = 8'hEE;
        step();
        bpInValid = 1'b0;
        checkVal("stray_pulse", stray, 1);
        checkVal("stray_no_rsp", rspValid, 0);
        step();
        checkVal("stray_one_cycle", stray, 0);

        // ---------------- clock gate low mid-WAIT ----------------
        sendCmd(1'b0, 7'h07, 8'h00);
        step();                                      // WAIT entry
        for (int i = 0; i < 3; i++) step();
        cg        = 1'b0;
        bpInValid = 1'b1;
        bpInData  = 8'hAB;
        for (int i = 0; i < 4; i++) begin
            step();
            checkVal("cg_no_rsp", rspValid, 0);
            checkVal("cg_bp_ready_held", bpInReady, 1);
            checkVal("cg_no_stray", stray, 0);
        end
        bpInValid = 1'b0;
        cg        = 1'b1;
        early = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (rspValid) early++;
        end
        checkVal("cg_frozen_count", early, 0);
        step();
        checkVal("cg_tmo_valid", rspValid, 1);
        checkVal("cg_tmo_flag", rspTimeout, 1);
        checkVal("cg_tmo_data", rspData, 8'h00);
        step();

        // ---------------- reset pulse in DATA ----------------
        sendCmd(1'b1, 7'h55, 8'h66);
        step();                                      // DATA
        checkVal("rstm_in_data", bpOutData, 8'h66);
        rst_n = 1'b0;
        #1;
        checkVal("rstm_bp_valid", bpOutValid, 0);
        checkVal("rstm_bp_data", bpOutData, 8'h00);
        checkVal("rstm_cmd_ready", cmdReady, 1);
        checkVal("rstm_bp_ready", bpInReady, 1);
        #1;
        rst_n     = 1'b1;
        bpInValid = 1'b1;
        bpInData  = 8'hCC;
        step();
        bpInValid = 1'b0;
        checkVal("rstm_late_stray", stray, 1);
        checkVal("rstm_late_no_rsp", rspValid, 0);
        step();
        checkVal("rstm_still_no_rsp", rspValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
